// File: rtl/vo_motion_pkg.sv
// Shared types and sizing for the per-frame motion estimator.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package vo_motion_pkg;

   localparam int MAX_PAIRS = 500;
   localparam int MAX_DISP  = 64;
   localparam int COOR_W    = 10;
   localparam int DISP_W    = 11;
   localparam int CNT_W     = $clog2(MAX_PAIRS + 1);
   localparam int SUM_W     = DISP_W + CNT_W;
   localparam int STEP_W    = $clog2(SUM_W);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DIV,
      DONE
   } me_state_e;

   // Two's-complement magnitude of a signed accumulator.
   function automatic logic [SUM_W-1:0] abs_sum(input logic [SUM_W-1:0] v);
      return v[SUM_W-1] ? SUM_W'(~v + 1'b1) : v;
   endfunction

   // Reapply the sign of the sum to an unsigned quotient (truncates toward zero).
   function automatic logic [DISP_W-1:0] apply_sign(input logic neg, input logic [DISP_W-1:0] mag);
      return neg ? DISP_W'(~mag + 1'b1) : mag;
   endfunction

endpackage

// File: rtl/motion_divider.sv
// Unsigned restoring divider, SUM_W-bit dividend by CNT_W-bit divisor.
// Latency: loads on start_i, then SUM_W iterations; done_o marks the last one.
// Backpressure: none; a new start_i simply restarts the division.
module motion_divider
   import vo_motion_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [SUM_W-1:0]  dividend_i,
   input  logic [CNT_W-1:0]  divisor_i,
   output logic              done_o,
   output logic [DISP_W-1:0] quotient_o
);

   logic [SUM_W-1:0]  quot_q, quot_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  dvsr_q, dvsr_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              busy_q, busy_d;
   logic [CNT_W:0]    trial;

   // One quotient bit per cycle: shift dividend MSB into the remainder and try to subtract.
   always_comb begin
      quot_d = quot_q;
      rem_d  = rem_q;
      dvsr_d = dvsr_q;
      step_d = step_q;
      busy_d = busy_q;
      trial  = {rem_q, quot_q[SUM_W-1]};
      if (start_i) begin
         quot_d = dividend_i;
         rem_d  = '0;
         dvsr_d = divisor_i;
         step_d = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (trial >= {1'b0, dvsr_q}) begin
            rem_d  = CNT_W'(trial - {1'b0, dvsr_q});
            quot_d = {quot_q[SUM_W-2:0], 1'b1};
         end else begin
            rem_d  = trial[CNT_W-1:0];
            quot_d = {quot_q[SUM_W-2:0], 1'b0};
         end
         step_d = step_q + 1'b1;
         if (step_q == STEP_W'(SUM_W - 1)) begin
            busy_d = 1'b0;
         end
      end
   end

   // Divider state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         quot_q <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
         step_q <= '0;
         busy_q <= 1'b0;
      end else begin
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dvsr_q <= dvsr_d;
         step_q <= step_d;
         busy_q <= busy_d;
      end
   end

   // High during the final iteration; the quotient is complete from the next cycle.
   assign done_o     = busy_q && (step_q == STEP_W'(SUM_W - 1));
   // The mean magnitude never exceeds MAX_DISP, so the low DISP_W bits hold it.
   assign quotient_o = quot_q[DISP_W-1:0];

endmodule

// File: rtl/match_motion_estimator.sv
// Per-frame global translation: mean (dx, dy) of inlier match displacements.
// Latency: i_end to o_valid is SUM_W+2 cycles (2 cycles for an empty frame).
// Backpressure: none; pairs accepted every ACC cycle, dropped while DIV/DONE.
module match_motion_estimator
   import vo_motion_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic              i_end,
   input  logic [COOR_W-1:0] i_src_coor_x,
   input  logic [COOR_W-1:0] i_src_coor_y,
   input  logic [COOR_W-1:0] i_dst_coor_x,
   input  logic [COOR_W-1:0] i_dst_coor_y,
   output logic              o_valid,
   output logic [DISP_W-1:0] o_dx,
   output logic [DISP_W-1:0] o_dy,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_overflow,
   output logic              o_busy
);

   localparam logic signed [DISP_W-1:0] DISP_LIM = DISP_W'(MAX_DISP);

   me_state_e                state_q, state_d;
   logic signed [SUM_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     ovf_q, ovf_d;
   logic                     div_start;
   logic                     div_done_x, div_done_y;
   logic [DISP_W-1:0]        quot_x, quot_y;

   logic                     o_valid_q;
   logic [DISP_W-1:0]        o_dx_q, o_dy_q;
   logic [CNT_W-1:0]         o_count_q;
   logic                     o_overflow_q;

   logic signed [DISP_W-1:0] dx, dy;
   logic signed [SUM_W-1:0]  dx_ext, dy_ext;
   logic                     inlier;

   // Displacement of the incoming pair; -1024 is always rejected by the range test.
   assign dx     = $signed({1'b0, i_dst_coor_x}) - $signed({1'b0, i_src_coor_x});
   assign dy     = $signed({1'b0, i_dst_coor_y}) - $signed({1'b0, i_src_coor_y});
   assign dx_ext = {{(SUM_W-DISP_W){dx[DISP_W-1]}}, dx};
   assign dy_ext = {{(SUM_W-DISP_W){dy[DISP_W-1]}}, dy};
   assign inlier = (dx >= -DISP_LIM) && (dx <= DISP_LIM) &&
                   (dy >= -DISP_LIM) && (dy <= DISP_LIM);

   // Frame FSM and accumulators; a pair arriving with i_end is folded in before dividing.
   always_comb begin
      state_d   = state_q;
      sum_x_d   = sum_x_q;
      sum_y_d   = sum_y_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      div_start = 1'b0;
      case (state_q)
         IDLE: state_d = ACC;
         ACC: begin
            if (i_valid && inlier) begin
               if (cnt_q == CNT_W'(MAX_PAIRS)) begin
                  ovf_d = 1'b1;
               end else begin
                  sum_x_d = sum_x_q + dx_ext;
                  sum_y_d = sum_y_q + dy_ext;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
            if (i_end) begin
               if (cnt_d == '0) begin
                  state_d = DONE;
               end else begin
                  state_d   = DIV;
                  div_start = 1'b1;
               end
            end
         end
         DIV: begin
            if (div_done_x && div_done_y) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = ACC;
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, accumulator and count registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         sum_x_q <= '0;
         sum_y_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_x_q <= sum_x_d;
         sum_y_q <= sum_y_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   motion_divider u_div_x (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .start_i    (div_start),
      .dividend_i (abs_sum(sum_x_d)),
      .divisor_i  (cnt_d),
      .done_o     (div_done_x),
      .quotient_o (quot_x)
   );

   motion_divider u_div_y (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .start_i    (div_start),
      .dividend_i (abs_sum(sum_y_d)),
      .divisor_i  (cnt_d),
      .done_o     (div_done_y),
      .quotient_o (quot_y)
   );

   // Result registers: updated only in DONE, held otherwise; an empty frame reports zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid_q    <= 1'b0;
         o_dx_q       <= '0;
         o_dy_q       <= '0;
         o_count_q    <= '0;
         o_overflow_q <= 1'b0;
      end else begin
         o_valid_q <= (state_q == DONE);
         if (state_q == DONE) begin
            o_dx_q       <= (cnt_q == '0) ? '0 : apply_sign(sum_x_q[SUM_W-1], quot_x);
            o_dy_q       <= (cnt_q == '0) ? '0 : apply_sign(sum_y_q[SUM_W-1], quot_y);
            o_count_q    <= cnt_q;
            o_overflow_q <= ovf_q;
         end
      end
   end

   assign o_valid    = o_valid_q;
   assign o_dx       = o_dx_q;
   assign o_dy       = o_dy_q;
   assign o_count    = o_count_q;
   assign o_overflow = o_overflow_q;
   assign o_busy     = (state_q == DIV);

endmodule
